mcs_fpro_bridge_mw: RTL and testbench
=====================================

// Module: mcs_fpro_bridge_mw
// PURPOSE
//  Multi-window, wait-state-aware bridge from the MicroBlaze MCS IO bus to N_WIN FPro bus slots.
//  Successor to the fixed two-slot (mmio/video) bridge: adds configurable read latency,
//  per-slot wait/stretch, byte enables to slaves, out-of-range detection and a sticky error flag.
//  Sits between cpu_unit and the mmio/video subsystems in the top level.
// PARAMETERS
//  BRG_BASE   32'hc000_0000  byte base address of the bridge space
//  N_WIN      2              number of FPro slots; each window is 2^(FP_ADDR_W+2) bytes
//  FP_ADDR_W  21             FPro word-address width; fp_addr = io_address[FP_ADDR_W+1:2]
//  RD_LAT     1              cycles from the fp_rd pulse to valid fp_rd_data (1..15)
//  TIMEOUT    255            max fp_wait cycles before forced completion (BRG_TIMEOUT_EN only)
// PORTS
//  clk            in   1           system clock
//  reset_n        in   1           synchronous reset, active low
//  io_addr_strobe in   1           MCS access strobe (one-cycle pulse)
//  io_read_strobe in   1           MCS read
//  io_write_strobe in  1           MCS write
//  io_byte_enable in   4           MCS byte enables
//  io_address     in   32          MCS byte address
//  io_write_data  in   32          MCS write data
//  io_read_data   out  32          read data to MCS
//  io_ready       out  1           one-cycle completion pulse to MCS
//  fp_cs          out  N_WIN       one-hot slot select
//  fp_wr, fp_rd   out  1 each      one-cycle access pulses, qualified by fp_cs
//  fp_addr        out  FP_ADDR_W   word address within the window
//  fp_wr_data     out  32          write data
//  fp_be          out  4           byte enables
//  fp_rd_data     in   N_WIN*32    per-slot read data; slot w = bits [32w+31:32w]
//  fp_wait        in   N_WIN       per-slot stretch request, sampled at the completion cycle
//  err_clr        in   1           clears brg_err
//  brg_err        out  1           sticky error: out-of-range access (or timeout)
// BEHAVIOUR
//  - Reset (reset_n=0 at a clk edge): state IDLE; all outputs 0, including io_read_data and brg_err.
//    Reset mid-access aborts the access: no io_ready, no further fp_* pulses.
//  - FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  - IDLE: on io_addr_strobe at cycle t, latch address, data, byte enables and direction.
//    If both read and write strobes are set, write wins.
//    Decode: offset = io_address - BRG_BASE; w = offset >> (FP_ADDR_W+2).
//    In range iff io_address >= BRG_BASE and w < N_WIN.
//  - Out of range: no fp_cs/fp_wr/fp_rd activity; io_ready at t+2; io_read_data=0; brg_err set.
//  - ISSUE (t+1): fp_cs[w]=1 with exactly one of fp_wr/fp_rd for exactly one cycle.
//    fp_addr, fp_wr_data and fp_be are held stable from t+1 until DONE.
//  - Write: the completion cycle is t+1. Read: the completion cycle is t+1+RD_LAT (counter in WAIT).
//  - At the completion cycle, if fp_wait[w]=0: the read captures fp_rd_data[w]; go to DONE.
//    Otherwise stay in WAIT and re-sample every cycle.
//  - DONE: io_ready=1 for exactly one cycle.
//    Nominal latency: write t+2, read t+2+RD_LAT.
//    io_read_data holds until the next read completes (write completions leave it unchanged).
//  - Strobes arriving outside IDLE are ignored (the MCS protocol forbids them).
//  - brg_err: set on error completion, cleared by err_clr; simultaneous set and clear -> set wins.
// CONFIGURATION
//  BRG_TIMEOUT_EN defined:
//    8-bit wait counter starts when WAIT begins stretching. If fp_wait[w] is still 1 after TIMEOUT
//    stretch cycles: complete anyway with io_read_data=32'hDEAD_BEEF (reads only), set brg_err,
//    return to IDLE through DONE.
//  BRG_TIMEOUT_EN undefined:
//    no counter logic; the bridge waits indefinitely on fp_wait; TIMEOUT is unused.
// STRUCTURE
//  - Package mcs_brg_pkg: state_t enum {IDLE, ISSUE, WAIT, DONE}; localparam BRG_TO_DATA=32'hDEAD_BEEF;
//    function win_idx(addr, base, aw) returning the window index.
//  - Sub-module mcs_brg_win_decode (combinational): address -> {in_range, one-hot sel, word addr}.
//  - Top module: FSM, latency/timeout counters, output registers.
// TESTING
//  1 Write 32'h1234_5678 to BRG_BASE+8, fp_wait=0 -> fp_cs=2'b01, fp_wr pulse at t+1,
//    fp_addr=2, fp_be=4'hF, io_ready at t+2.
//  2 RD_LAT=3: read BRG_BASE+0x80_0004, slot 1 data 32'hCAFE_0001 -> fp_cs=2'b10,
//    fp_rd at t+1, io_ready at t+5, io_read_data=32'hCAFE_0001.
//  3 Read slot 0, fp_wait held 4 cycles -> io_ready at t+7 with RD_LAT=1; data sampled after fp_wait falls.
//  4 Read BRG_BASE+0x100_0000 with N_WIN=2 -> no fp_cs, io_ready at t+2, data 0, brg_err=1;
//    err_clr -> brg_err=0 next cycle.
//  5 BRG_TIMEOUT_EN, TIMEOUT=10, fp_wait stuck high -> io_ready after 10 stretch cycles,
//    data 32'hDEAD_BEEF, brg_err=1.
//  6 reset_n low during a read stretch -> no io_ready, all outputs 0, next access behaves as in test 1.

Source files
------------

// File: rtl/mcs_brg_pkg.sv
// Shared types and helpers for the multi-window MCS -> FPro bridge.
package mcs_brg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Read data returned when a stretched access is forced to complete.
    localparam logic [31:0] BRG_TO_DATA = 32'hDEAD_BEEF;

    // Window index of a byte address relative to the bridge base.
    // Addresses below the base wrap to a huge index; callers check that separately.
    function automatic logic [31:0] win_idx(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int          aw);
        logic [31:0] off;
        off = addr - base;
        return off >> (aw + 2);
    endfunction

endpackage

// File: rtl/mcs_brg_win_decode.sv
// Combinational window decoder: byte address -> in-range flag, one-hot slot
// select and word address inside the window.
module mcs_brg_win_decode
    import mcs_brg_pkg::*;
#(
    parameter logic [31:0] BRG_BASE  = 32'hc000_0000,
    parameter int          N_WIN     = 2,
    parameter int          FP_ADDR_W = 21
) (
    input  logic [31:0]          i_addr,
    output logic                 o_in_range,
    output logic [N_WIN-1:0]     o_sel,
    output logic [FP_ADDR_W-1:0] o_waddr
);

    logic [31:0] w_idx;

    assign w_idx      = win_idx(i_addr, BRG_BASE, FP_ADDR_W);
    assign o_in_range = (i_addr >= BRG_BASE) && (w_idx < 32'(N_WIN));
    assign o_waddr    = i_addr[FP_ADDR_W+1:2];

    // One-hot select of the addressed window, empty when out of range.
    always_comb begin
        o_sel = '0;
        for (int w = 0; w < N_WIN; w++) begin
            o_sel[w] = o_in_range && (w_idx == 32'(w));
        end
    end

endmodule

// File: rtl/mcs_fpro_bridge_mw.sv
// MicroBlaze MCS IO bus to N_WIN FPro slots, with configurable read latency,
// per-slot wait stretching, byte enables, out-of-range detection and a sticky
// error flag. Optional macro BRG_TIMEOUT_EN bounds the stretch to TIMEOUT cycles.
module mcs_fpro_bridge_mw
    import mcs_brg_pkg::*;
#(
    parameter logic [31:0] BRG_BASE  = 32'hc000_0000,
    parameter int          N_WIN     = 2,
    parameter int          FP_ADDR_W = 21,
    parameter int          RD_LAT    = 1,
    parameter int          TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  io_addr_strobe,
    input  logic                  io_read_strobe,
    input  logic                  io_write_strobe,
    input  logic [3:0]            io_byte_enable,
    input  logic [31:0]           io_address,
    input  logic [31:0]           io_write_data,
    output logic [31:0]           io_read_data,
    output logic                  io_ready,
    output logic [N_WIN-1:0]      fp_cs,
    output logic                  fp_wr,
    output logic                  fp_rd,
    output logic [FP_ADDR_W-1:0]  fp_addr,
    output logic [31:0]           fp_wr_data,
    output logic [3:0]            fp_be,
    input  logic [N_WIN*32-1:0]   fp_rd_data,
    input  logic [N_WIN-1:0]      fp_wait,
    input  logic                  err_clr,
    output logic                  brg_err
);

    localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_is_wr;
    logic                   r_in_range;
    logic [N_WIN-1:0]       r_sel;
    logic [FP_ADDR_W-1:0]   r_addr;
    logic [31:0]            r_wdata;
    logic [3:0]             r_be;
    logic [3:0]             r_lat_cnt;
    logic [31:0]            r_rdata;
    logic                   r_err;

    logic                   w_in_range;
    logic [N_WIN-1:0]       w_sel;
    logic [FP_ADDR_W-1:0]   w_waddr;
    logic                   w_start;
    logic                   w_wait;
    logic [31:0]            w_slot_data;
    logic                   w_lat_done;
    logic                   w_check;
    logic                   w_capture;
    logic                   w_force;
    logic                   w_oor;

    mcs_brg_win_decode #(
        .BRG_BASE  (BRG_BASE),
        .N_WIN     (N_WIN),
        .FP_ADDR_W (FP_ADDR_W)
    ) u_decode (
        .i_addr     (io_address),
        .o_in_range (w_in_range),
        .o_sel      (w_sel),
        .o_waddr    (w_waddr)
    );

    // A new access only starts from IDLE; strobes in other states are dropped.
    assign w_start = (r_state == IDLE) && io_addr_strobe
                     && (io_read_strobe || io_write_strobe);

    assign w_wait     = |(fp_wait & r_sel);
    // Writes complete in ISSUE; reads once the latency counter expires in WAIT.
    assign w_lat_done = r_is_wr || (r_lat_cnt == LAT_M1);
    assign w_check    = r_in_range
                        && (((r_state == ISSUE) && r_is_wr)
                            || ((r_state == WAIT) && w_lat_done));
    assign w_capture  = w_check && !w_wait;
    assign w_oor      = (r_state == ISSUE) && !r_in_range;

    // Read data of the selected slot.
    always_comb begin
        w_slot_data = '0;
        for (int w = 0; w < N_WIN; w++) begin
            if (r_sel[w]) begin
                w_slot_data = w_slot_data | fp_rd_data[32*w +: 32];
            end
        end
    end

`ifdef BRG_TIMEOUT_EN
    localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);
    logic [7:0] r_to_cnt;

    // Count stretch cycles of the current access.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_to_cnt <= '0;
        end else if (w_check && w_wait) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    assign w_force = w_check && w_wait && (r_to_cnt == TO_M1);
`else
    assign w_force = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and the single-cycle bus pulses.
    always_comb begin
        w_state_nxt = r_state;
        fp_cs       = '0;
        fp_wr       = 1'b0;
        fp_rd       = 1'b0;
        io_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                fp_cs = r_sel;
                fp_wr = r_in_range && r_is_wr;
                fp_rd = r_in_range && !r_is_wr;
                if (!r_in_range || w_capture || w_force) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (w_capture || w_force) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                io_ready    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Latch the access and its decode when it is accepted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_is_wr    <= 1'b0;
            r_in_range <= 1'b0;
            r_sel      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
        end else if (w_start) begin
            r_is_wr    <= io_write_strobe;
            r_in_range <= w_in_range;
            r_sel      <= w_sel;
            r_addr     <= w_waddr;
            r_wdata    <= io_write_data;
            r_be       <= io_byte_enable;
        end
    end

    // Read latency counter; holds at its terminal value while stretched.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_lat_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_lat_cnt <= '0;
        end else if ((r_state == WAIT) && !w_lat_done) begin
            r_lat_cnt <= r_lat_cnt + 4'd1;
        end
    end

    // Returned read data; only read completions update it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else if (!r_is_wr) begin
            if (w_oor) begin
                r_rdata <= '0;
            end else if (w_capture) begin
                r_rdata <= w_slot_data;
            end else if (w_force) begin
                r_rdata <= BRG_TO_DATA;
            end
        end
    end

    // Sticky error flag; a new error beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_oor || w_force) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign fp_addr      = r_addr;
    assign fp_wr_data   = r_wdata;
    assign fp_be        = r_be;
    assign io_read_data = r_rdata;
    assign brg_err      = r_err;

endmodule

// File: tb/tb_mcs_fpro_bridge_mw.sv
// Scoreboard bench for mcs_fpro_bridge_mw (RD_LAT=3, N_WIN=2, FP_ADDR_W=21).
// The timeout case is exercised only when BRG_TIMEOUT_EN is defined.
module tb_mcs_fpro_bridge_mw;

    localparam int LAT = 3;

    typedef struct {
        int          cyc;
        logic [1:0]  cs;
        logic        wr;
        logic        rd;
        logic [20:0] fa;
        logic [31:0] wd;
        logic [3:0]  be;
    } fp_exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        err;
    } rsp_exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [3:0]  io_byte_enable;
    logic [31:0] io_address, io_write_data;
    logic [31:0] io_read_data;
    logic        io_ready;
    logic [1:0]  fp_cs;
    logic        fp_wr, fp_rd;
    logic [20:0] fp_addr;
    logic [31:0] fp_wr_data;
    logic [3:0]  fp_be;
    logic [63:0] fp_rd_data;
    logic [1:0]  fp_wait;
    logic        err_clr;
    logic        brg_err;
    logic [31:0] sd0, sd1;

    int       cyc = 0;
    int       checks = 0;
    int       errors = 0;
    int       n_rsp = 0;
    fp_exp_t  fp_q[$];
    rsp_exp_t rsp_q[$];
    fp_exp_t  mf;
    rsp_exp_t mr;

    assign fp_rd_data = {sd1, sd0};

    mcs_fpro_bridge_mw #(
        .BRG_BASE  (32'hc000_0000),
        .N_WIN     (2),
        .FP_ADDR_W (21),
        .RD_LAT    (LAT),
        .TIMEOUT   (10)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .io_addr_strobe  (io_addr_strobe),
        .io_read_strobe  (io_read_strobe),
        .io_write_strobe (io_write_strobe),
        .io_byte_enable  (io_byte_enable),
        .io_address      (io_address),
        .io_write_data   (io_write_data),
        .io_read_data    (io_read_data),
        .io_ready        (io_ready),
        .fp_cs           (fp_cs),
        .fp_wr           (fp_wr),
        .fp_rd           (fp_rd),
        .fp_addr         (fp_addr),
        .fp_wr_data      (fp_wr_data),
        .fp_be           (fp_be),
        .fp_rd_data      (fp_rd_data),
        .fp_wait         (fp_wait),
        .err_clr         (err_clr),
        .brg_err         (brg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_io_ready"}, 64'(io_ready), 64'd0);
        chk({tag, "_io_read_data"}, 64'(io_read_data), 64'd0);
        chk({tag, "_fp_cs"}, 64'(fp_cs), 64'd0);
        chk({tag, "_fp_wr_rd"}, 64'({fp_wr, fp_rd}), 64'd0);
        chk({tag, "_fp_addr"}, 64'(fp_addr), 64'd0);
        chk({tag, "_fp_wr_data"}, 64'(fp_wr_data), 64'd0);
        chk({tag, "_fp_be"}, 64'(fp_be), 64'd0);
        chk({tag, "_brg_err"}, 64'(brg_err), 64'd0);
    endtask

    // Monitor: compare every bus pulse and every completion against the queues.
    always @(negedge clk) begin
        if ((fp_cs != 2'b00) || fp_wr || fp_rd) begin
            if (fp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fp_unexpected: got cs=%0h wr=%0b rd=%0b expected no access (cycle %0d)",
                         fp_cs, fp_wr, fp_rd, cyc);
            end else begin
                mf = fp_q.pop_front();
                chk("fp_cycle", 64'(cyc), 64'(mf.cyc));
                chk("fp_cs", 64'(fp_cs), 64'(mf.cs));
                chk("fp_wr", 64'(fp_wr), 64'(mf.wr));
                chk("fp_rd", 64'(fp_rd), 64'(mf.rd));
                chk("fp_addr", 64'(fp_addr), 64'(mf.fa));
                chk("fp_wr_data", 64'(fp_wr_data), 64'(mf.wd));
                chk("fp_be", 64'(fp_be), 64'(mf.be));
            end
        end
        if (io_ready) begin
            n_rsp++;
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL io_ready_unexpected: got io_ready=1 expected 0 (cycle %0d)", cyc);
            end else begin
                mr = rsp_q.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(mr.cyc));
                chk("rsp_read_data", 64'(io_read_data), 64'(mr.rd));
                chk("rsp_brg_err", 64'(brg_err), 64'(mr.err));
            end
        end
    end

    // Issue one MCS access and push its expected bus pulse and completion.
    // wdrop > 0: release fp_wait at cycle t+wdrop and present ddrop on the stretched slot.
    task automatic do_acc(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be,
                          input logic [1:0] wmask, input int wdrop, input logic [31:0] ddrop,
                          input logic [1:0] ecs, input logic [20:0] efa, input int edly,
                          input logic [31:0] erd, input logic eerr, input bit eresp);
        int       t;
        int       n0;
        fp_exp_t  f;
        rsp_exp_t r;
        @(posedge clk);
        #1;
        io_addr_strobe  = 1'b1;
        io_read_strobe  = rd;
        io_write_strobe = wr;
        io_address      = addr;
        io_write_data   = wd;
        io_byte_enable  = be;
        fp_wait         = wmask;
        t               = cyc;
        if (ecs != 2'b00) begin
            f.cyc = t + 1;
            f.cs  = ecs;
            f.wr  = wr;
            f.rd  = !wr;
            f.fa  = efa;
            f.wd  = wd;
            f.be  = be;
            fp_q.push_back(f);
        end
        if (eresp) begin
            r.cyc = t + edly;
            r.rd  = erd;
            r.err = eerr;
            rsp_q.push_back(r);
        end
        n0 = n_rsp;
        @(posedge clk);
        #1;
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        io_address      = 32'h0000_0000;
        io_write_data   = 32'h5A5A_5A5A;
        if (eresp) begin
            for (int i = 0; i < 60 && n_rsp == n0; i++) begin
                @(posedge clk);
                #1;
                if (wdrop > 0 && cyc == t + wdrop) begin
                    fp_wait = 2'b00;
                    if (wmask[0]) sd0 = ddrop;
                    if (wmask[1]) sd1 = ddrop;
                end
            end
            if (n_rsp == n0) begin
                checks++;
                errors++;
                $display("FAIL rsp_timeout: got no io_ready expected one by cycle %0d", t + edly);
            end
            fp_wait = 2'b00;
        end
    endtask

    task automatic clear_err();
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("err_clr", 64'(brg_err), 64'd0);
    endtask

    initial begin
        reset_n         = 1'b0;
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        io_byte_enable  = 4'h0;
        io_address      = 32'h0;
        io_write_data   = 32'h0;
        fp_wait         = 2'b00;
        err_clr         = 1'b0;
        sd0             = 32'h0;
        sd1             = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset_n = 1'b1;

        // Write to slot 0, word 2.
        do_acc(1, 0, 32'hc000_0008, 32'h1234_5678, 4'hF, 2'b00, 0, 0,
               2'b01, 21'd2, 2, 32'h0, 1'b0, 1);
        // Read slot 1, word 1, three-cycle latency.
        sd1 = 32'hCAFE_0001;
        do_acc(0, 1, 32'hc080_0004, 32'h0, 4'hF, 2'b00, 0, 0,
               2'b10, 21'd1, 2 + LAT, 32'hCAFE_0001, 1'b0, 1);
        // Write stretched two cycles; read data must stay put.
        do_acc(1, 0, 32'hc080_0010, 32'hA5A5_0000, 4'b0011, 2'b10, 3, 32'hCAFE_0001,
               2'b10, 21'd4, 4, 32'hCAFE_0001, 1'b0, 1);
        // Read slot 0 stretched four cycles; the value present when wait falls is returned.
        sd0 = 32'h0BAD_0BAD;
        do_acc(0, 1, 32'hc000_0020, 32'h0, 4'hF, 2'b01, 2 + LAT + 3, 32'h1111_2222,
               2'b01, 21'd8, 2 + LAT + 4, 32'h1111_2222, 1'b0, 1);
        // Both strobes: write wins, partial byte enable.
        do_acc(1, 1, 32'hc000_0004, 32'h0000_00FF, 4'h1, 2'b00, 0, 0,
               2'b01, 21'd1, 2, 32'h1111_2222, 1'b0, 1);
        // Just past the last window.
        do_acc(0, 1, 32'hc100_0000, 32'h0, 4'hF, 2'b00, 0, 0,
               2'b00, 21'd0, 2, 32'h0, 1'b1, 1);
        clear_err();
        // Read of slot 1 word 2, then below-base access.
        sd1 = 32'h5555_AAAA;
        do_acc(0, 1, 32'hc080_0008, 32'h0, 4'hF, 2'b00, 0, 0,
               2'b10, 21'd2, 2 + LAT, 32'h5555_AAAA, 1'b0, 1);
        do_acc(0, 1, 32'hbfff_fffc, 32'h0, 4'hF, 2'b00, 0, 0,
               2'b00, 21'd0, 2, 32'h0, 1'b1, 1);
        clear_err();
`ifdef BRG_TIMEOUT_EN
        // Stuck wait: forced completion after ten stretch cycles.
        do_acc(0, 1, 32'hc080_000c, 32'h0, 4'hF, 2'b10, 0, 0,
               2'b10, 21'd3, 1 + LAT + 10, 32'hDEAD_BEEF, 1'b1, 1);
        clear_err();
`endif
        // Give the bridge a non-zero read value, then reset in the middle of a stretch.
        sd1 = 32'h7777_8888;
        do_acc(0, 1, 32'hc080_0000, 32'h0, 4'hF, 2'b00, 0, 0,
               2'b10, 21'd0, 2 + LAT, 32'h7777_8888, 1'b0, 1);
        do_acc(0, 1, 32'hc080_0000, 32'h0, 4'hF, 2'b10, 0, 0,
               2'b10, 21'd0, 0, 32'h0, 1'b0, 0);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("midreset");
        reset_n = 1'b1;
        fp_wait = 2'b00;
        repeat (6) @(posedge clk);
        #1;
        do_acc(1, 0, 32'hc000_0008, 32'h1234_5678, 4'hF, 2'b00, 0, 0,
               2'b01, 21'd2, 2, 32'h0, 1'b0, 1);

        repeat (5) @(posedge clk);
        #1;
        chk("fp_q_drained", 64'(fp_q.size()), 64'd0);
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
